truth_table_sweeper: RTL and testbench

- Sequential, parametrised successor to the fixed 3-input combinational function blocks.
- Holds a programmable N-input Boolean function as a truth-table vector (LUT).
- On start, sweeps every input combination in ascending order and emits each row over a valid/ready handshake.
- Counts minterms and replaces hand-written stimulus/monitor sweeps in the lab benches.

---
 rtl/truth_table_pkg.sv | 16 +
 rtl/lut_select.sv | 16 +
 rtl/truth_table_sweeper.sv | 102 ++++++++++
 tb/tb_truth_table_sweeper.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared encodings for the truth-table sweeper.
//   state_t       : sweeper FSM states (IDLE / SWEEP / FINISH)
//   MODE_ALL      : emit every row of the table
//   MODE_MINTERMS : emit only rows whose function value is 1
package truth_table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic MODE_ALL      = 1'b0;
  localparam logic MODE_MINTERMS = 1'b1;

endpackage

// File: rtl/lut_select.sv
// Combinational ROWS-to-1 truth-table lookup.
//   lut     : truth table, bit i = f(row i)
//   sel     : row number {in[N_IN-1]..in[0]}
//   bit_out : f(sel)
module lut_select #(
  parameter  int N_IN = 3,
  localparam int ROWS = 1 << N_IN
) (
  input  logic [ROWS-1:0] lut,
  input  logic [N_IN-1:0] sel,
  output logic            bit_out
);

  assign bit_out = lut[sel];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a programmable N_IN-input truth table in ascending row order and
// emits each row over a valid/ready handshake, counting emitted minterms.
//   clk, reset_n   : rising-edge clock, async active-low reset
//   start          : begin a sweep (only looked at in IDLE)
//   mode           : 0 = emit all rows, 1 = emit only rows with f=1
//   cfg_lut        : truth table, latched at start
//   busy / done    : sweep in progress / one-cycle end pulse
//   row_valid, row_ready, row_in, row_out : row handshake
//   minterm_count  : emitted rows with row_out=1, held until next start
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter  int N_IN = 3,
  localparam int ROWS = 1 << N_IN
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            mode,
  input  logic [ROWS-1:0] cfg_lut,
  output logic            busy,
  output logic            done,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [N_IN-1:0] row_in,
  output logic            row_out,
  output logic [N_IN:0]   minterm_count
);

  // Index carries one spare bit so the last-row compare is never confused
  // with a wrapped-around row 0.
  localparam logic [N_IN:0] LAST = (N_IN+1)'(ROWS - 1);

  state_t          state, state_n;
  logic [N_IN:0]   index, index_n;
  logic [N_IN:0]   count_n;
  logic [ROWS-1:0] lut_q;
  logic            mode_q;
  logic            lut_bit;
  logic            sweeping;
  logic            advance;

  lut_select #(.N_IN(N_IN)) u_sel (
    .lut     (lut_q),
    .sel     (index[N_IN-1:0]),
    .bit_out (lut_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      index         <= '0;
      minterm_count <= '0;
      lut_q         <= '0;
      mode_q        <= MODE_ALL;
    end else begin
      state         <= state_n;
      index         <= index_n;
      minterm_count <= count_n;
      if (state == ST_IDLE && start) begin
        lut_q  <= cfg_lut;
        mode_q <= mode;
      end
    end
  end

  always_comb begin
    state_n   = state;
    index_n   = index;
    count_n   = minterm_count;
    sweeping  = (state == ST_SWEEP);
    // Outputs depend only on registered state, so a presented row cannot
    // change until the index moves, i.e. until the handshake edge.
    row_valid = sweeping && (mode_q == MODE_ALL || lut_bit);
    // Rows skipped in minterm mode advance without waiting for ready.
    advance   = sweeping && (row_valid ? row_ready : 1'b1);
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SWEEP;
          index_n = '0;
          count_n = '0;
        end
      end
      ST_SWEEP: begin
        if (advance) begin
          if (row_valid && lut_bit) count_n = minterm_count + (N_IN+1)'(1);
          if (index == LAST) state_n = ST_FINISH;
          else               index_n = index + (N_IN+1)'(1);
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign busy    = sweeping;
  assign done    = (state == ST_FINISH);
  assign row_in  = sweeping ? index[N_IN-1:0] : '0;
  assign row_out = sweeping && lut_bit;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, mode = 1'b0, row_ready = 1'b1;
  logic [7:0] cfg_lut = 8'h00;
  logic       busy, done, row_valid, row_out;
  logic [2:0] row_in;
  logic [3:0] minterm_count;

  // extra builds at the parameter extremes
  logic        start_p = 1'b0;
  logic [1:0]  lut1 = '0;
  logic [63:0] lut6 = '0;
  logic        busy1, done1, valid1, out1, busy6, done6, valid6, out6;
  logic [0:0]  in1;
  logic [5:0]  in6;
  logic [1:0]  cnt1;
  logic [6:0]  cnt6;

  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .cfg_lut(cfg_lut),
    .busy(busy), .done(done), .row_valid(row_valid), .row_ready(row_ready),
    .row_in(row_in), .row_out(row_out), .minterm_count(minterm_count));

  truth_table_sweeper #(.N_IN(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_p), .mode(1'b0), .cfg_lut(lut1),
    .busy(busy1), .done(done1), .row_valid(valid1), .row_ready(1'b1),
    .row_in(in1), .row_out(out1), .minterm_count(cnt1));

  truth_table_sweeper #(.N_IN(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .start(start_p), .mode(1'b0), .cfg_lut(lut6),
    .busy(busy6), .done(done6), .row_valid(valid6), .row_ready(1'b1),
    .row_in(in6), .row_out(out6), .minterm_count(cnt6));

  task automatic kick(input logic [7:0] lut, input logic m);
    cfg_lut = lut; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vec++;
    if ({busy, done, row_valid, row_out, row_in, minterm_count} !== 11'd0) begin
      errs++; $display("FAIL reset_outputs: got %b want 0", {busy, done, row_valid, row_out, row_in, minterm_count});
    end
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    vec++;
    if ({busy, done, row_valid} !== 3'b000) begin
      errs++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, row_valid});
    end
  endtask

  task automatic test_mode_all();
    int exp_out[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    row_ready = 1'b1;
    kick(8'h44, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vec++;
      if ({busy, row_valid, row_in, row_out} !== {1'b1, 1'b1, 3'(k), 1'(exp_out[k])}) begin
        errs++; $display("FAIL all_row%0d: got v=%b in=%0d out=%b want v=1 in=%0d out=%0d",
                         k, row_valid, row_in, row_out, k, exp_out[k]);
      end
      @(posedge clk); #1;
    end
    vec++;
    if ({done, busy, row_valid, minterm_count} !== {3'b100, 4'd2}) begin
      errs++; $display("FAIL all_done: got d=%b b=%b v=%b cnt=%0d want d=1 b=0 v=0 cnt=2",
                       done, busy, row_valid, minterm_count);
    end
    @(posedge clk); #1;
    vec++;
    if ({done, minterm_count} !== {1'b0, 4'd2}) begin
      errs++; $display("FAIL all_hold: got d=%b cnt=%0d want d=0 cnt=2", done, minterm_count);
    end
  endtask

  task automatic test_mode_min();
    int exp_v[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int hs = 0, bad = 0;
    logic [2:0] got[2];
    row_ready = 1'b1;
    kick(8'h44, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (row_valid !== 1'(exp_v[k]) || busy !== 1'b1) bad++;
      if (row_valid && row_ready) begin
        if (hs < 2) got[hs] = row_in;
        hs++;
      end
      @(posedge clk); #1;
    end
    vec++;
    if (bad !== 0) begin
      errs++; $display("FAIL min_valid_pattern: got %0d bad cycles want 0", bad);
    end
    vec++;
    if (hs !== 2 || got[0] !== 3'b010 || got[1] !== 3'b110) begin
      errs++; $display("FAIL min_handshakes: got n=%0d %b %b want n=2 010 110", hs, got[0], got[1]);
    end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd2}) begin
      errs++; $display("FAIL min_done: got d=%b cnt=%0d want d=1 cnt=2", done, minterm_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int exp_out[8] = '{1, 0, 1, 0, 0, 1, 0, 1}; // 8'hA5
    int r = 0, stall = 0, bad = 0;
    kick(8'hA5, 1'b0);
    for (int c = 0; c < 20 && r < 8; c++) begin
      if ({row_valid, row_in, row_out} !== {1'b1, 3'(r), 1'(exp_out[r]) }) bad++;
      if (r == 5 && stall < 3) begin row_ready = 1'b0; stall++; end
      else begin row_ready = 1'b1; r++; end
      @(posedge clk); #1;
    end
    row_ready = 1'b1;
    vec++;
    if (bad !== 0 || r !== 8 || stall !== 3) begin
      errs++; $display("FAIL stall_rows: got bad=%0d rows=%0d stalls=%0d want 0 8 3", bad, r, stall);
    end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd4}) begin
      errs++; $display("FAIL stall_done: got d=%b cnt=%0d want d=1 cnt=4", done, minterm_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_full();
    int nv = 0, early = 0;
    kick(8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (row_valid) nv++;
      if (done || !busy) early++;
      @(posedge clk); #1;
    end
    vec++;
    if (nv !== 0 || early !== 0) begin
      errs++; $display("FAIL zero_lut_sweep: got valids=%0d early=%0d want 0 0", nv, early);
    end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd0}) begin
      errs++; $display("FAIL zero_lut_done: got d=%b cnt=%0d want d=1 cnt=0", done, minterm_count);
    end
    @(posedge clk); #1;
    kick(8'hFF, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd8}) begin
      errs++; $display("FAIL full_lut_count: got d=%b cnt=%0d want d=1 cnt=8", done, minterm_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore();
    int exp_out[8] = '{1, 1, 1, 1, 0, 0, 0, 0}; // 8'h0F
    int bad = 0;
    kick(8'h0F, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if ({row_valid, row_in, row_out} !== {1'b1, 3'(k), 1'(exp_out[k])}) bad++;
      if (k == 2) begin start = 1'b1; cfg_lut = 8'hF0; mode = 1'b1; end
      if (k == 5) start = 1'b0;
      @(posedge clk); #1;
    end
    vec++;
    if (bad !== 0) begin
      errs++; $display("FAIL ignore_rows: got %0d bad rows want 0", bad);
    end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd4}) begin
      errs++; $display("FAIL ignore_done: got d=%b cnt=%0d want d=1 cnt=4", done, minterm_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int bad = 0;
    kick(8'h44, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if ({row_in, minterm_count} !== {3'd4, 4'd1}) begin
      errs++; $display("FAIL pre_reset: got in=%0d cnt=%0d want in=4 cnt=1", row_in, minterm_count);
    end
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if ({busy, row_valid, done, row_in, minterm_count} !== 10'd0) begin
      errs++; $display("FAIL async_reset: got %b want 0", {busy, row_valid, done, row_in, minterm_count});
    end
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    vec++;
    if (bad !== 0) begin
      errs++; $display("FAIL no_done_after_reset: got %0d bad cycles want 0", bad);
    end
    kick(8'h44, 1'b0);
    vec++;
    if ({row_valid, row_in} !== {1'b1, 3'd0}) begin
      errs++; $display("FAIL restart_row0: got v=%b in=%0d want v=1 in=0", row_valid, row_in);
    end
    repeat (8) begin @(posedge clk); #1; end
    vec++;
    if ({done, minterm_count} !== {1'b1, 4'd2}) begin
      errs++; $display("FAIL restart_done: got d=%b cnt=%0d want d=1 cnt=2", done, minterm_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_params();
    int r1 = 0, r6 = 0, d1 = -1, d6 = -1, badseq = 0;
    lut1 = 2'b10;
    lut6 = {32{2'b10}};
    start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (valid1) r1++;
      if (done1 && d1 < 0) d1 = c;
      if (valid6) begin
        if (in6 !== 6'(r6) || out6 !== 1'(r6 & 1)) badseq++;
        r6++;
      end
      if (done6 && d6 < 0) d6 = c;
      @(posedge clk); #1;
    end
    vec++;
    if (r1 !== 2 || d1 !== 2 || cnt1 !== 2'd1) begin
      errs++; $display("FAIL n1_sweep: got rows=%0d done@%0d cnt=%0d want 2 2 1", r1, d1, cnt1);
    end
    vec++;
    if (r6 !== 64 || d6 !== 64 || cnt6 !== 7'd32 || badseq !== 0) begin
      errs++; $display("FAIL n6_sweep: got rows=%0d done@%0d cnt=%0d badseq=%0d want 64 64 32 0",
                       r6, d6, cnt6, badseq);
    end
  endtask

  initial begin
    test_reset();
    test_mode_all();
    test_mode_min();
    test_stall();
    test_zero_full();
    test_ignore();
    test_async_reset();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
